fetch_packet_splitter: RTL and testbench
========================================

FETCH_PACKET_SPLITTER -- requirements
Module: fetch_packet_splitter

Interface
REQ-001 Parameter VADDR_BITS, 40, pc width.
REQ-002 Parameter NUM_WORDS, 4, 32-bit instruction slots per packet (data width 32*NUM_WORDS, mask width 2*NUM_WORDS).
REQ-003 One clock; reset is asynchronous and active-high; ports named clock and reset.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  async active-high reset.
REQ-006 io_flush  in  1  discard held packet; highest priority.
REQ-007 io_enq_valid / io_enq_ready  in / out  1 / 1  packet handshake.
REQ-008 io_enq_bits_pc  in  40  packet pc; io_enq_bits_data in 128; io_enq_bits_mask in 8 (halfword valid bits).
REQ-009 io_enq_bits_xcpt_pf_inst, io_enq_bits_xcpt_ae_inst  in  1 each  fetch exceptions.
REQ-010 io_enq_bits_ghist_old_history in 64; _current_saw_branch_not_taken, _new_saw_branch_not_taken, _new_saw_branch_taken in 1 each; _ras_idx in 5.
REQ-011 io_deq_valid / io_deq_ready  out / in  1 / 1  instruction handshake.
REQ-012 io_deq_bits_pc out 40; io_deq_bits_inst out 32; io_deq_bits_slot out 2; io_deq_bits_last out 1 (final output of packet).
REQ-013 io_deq_bits_xcpt_pf_inst, io_deq_bits_xcpt_ae_inst, io_deq_bits_ghist_* (all five fields)  out  as enq widths  copied from held packet.

Function
REQ-014 Slot i SHALL be valid iff mask[2i] & mask[2i+1]; slot i instruction = data[32i+31:32i].
REQ-015 States SHALL be IDLE and SPLIT; IDLE -> SPLIT on enq fire with nonzero effective work; SPLIT -> IDLE on deq fire with last=1 and no same-cycle enq.
REQ-016 Enq fire (io_enq_valid & io_enq_ready) SHALL latch all packet fields and a remaining-slot mask in the same edge.
REQ-017 io_enq_ready SHALL be 1 in IDLE, and in SPLIT only when io_deq_valid & io_deq_ready & io_deq_bits_last (zero-bubble back-to-back).
REQ-018 In SPLIT, io_deq_valid=1 and the lowest remaining valid slot SHALL be presented; deq fire clears that slot's bit.
REQ-019 io_deq_bits_pc SHALL equal {pc[39:4], 4'b0} + 4*slot, modulo 2^40 (wraps).
REQ-020 io_deq_bits_last SHALL be 1 iff the presented slot is the highest remaining valid slot.
REQ-021 Packet with either xcpt bit set SHALL produce exactly one output: slot 0, inst 0, pc = packet pc unaligned, last=1, xcpt bits passed through, regardless of mask.
REQ-022 Packet with no xcpt and no valid slot SHALL be consumed and dropped, no output, state stays IDLE.
REQ-023 Latency: first output SHALL appear the cycle after enq fire; one output per cycle while io_deq_ready=1.
REQ-024 Outputs SHALL hold stable while io_deq_valid & ~io_deq_ready.
REQ-025 io_flush SHALL force IDLE and clear the remaining mask next edge, force io_enq_ready=0, and block enq in that cycle.

Reset
REQ-026 Reset SHALL set state IDLE, remaining mask 0, io_deq_valid 0, io_enq_ready 1 (once reset deasserts); data registers need no reset and outputs other than valid are don't-care while invalid.
REQ-027 Reset asserted mid-packet SHALL drop the packet immediately (asynchronously) with no further outputs.

Structure
REQ-028 Shared package SHALL hold the fetch-packet and ghist field widths, NUM_WORDS, and the state enumeration.
REQ-029 One sub-module, slot_select, SHALL be a combinational lowest-set/highest-set finder over the remaining mask.

Verification
REQ-030 pc=0x1000, mask=0xFF, deq_ready=1 -> 4 outputs on consecutive cycles, pc 0x1000/4/8/C, last only on 0x100C.
REQ-031 pc=0x2008, mask=0x33 -> slots 0,2 only, pc 0x2000 and 0x2008, second last=1; next packet accepted same cycle.
REQ-032 xcpt_pf_inst=1, mask=0xFF, pc=0x3006 -> single output pc 0x3006, inst 0, last=1, pf=1.
REQ-033 mask=0x00, no xcpt -> enq accepted, no deq_valid, next packet accepted following cycle.
REQ-034 deq_ready=0 for 3 cycles mid-packet -> outputs stable, enq_ready=0; flush asserted then -> deq_valid=0 next cycle.
REQ-035 pc=0xFF_FFFF_FFF0, mask=0xC0 -> single output pc 0xFF_FFFF_FFFC; random mask/ready run matches scoreboard.

Source files
------------

// File: rtl/fetch_packet_splitter_pkg.sv
// Shared widths, ghist bundle and state encoding for the fetch packet splitter.
package fetch_packet_splitter_pkg;
  localparam int VADDR_BITS_DEF = 40;
  localparam int NUM_WORDS_DEF  = 4;
  localparam int INST_BITS      = 32;
  localparam int GHIST_BITS     = 64;
  localparam int RAS_IDX_BITS   = 5;

  typedef enum logic {S_IDLE = 1'b0, S_SPLIT = 1'b1} state_e;

  typedef struct packed {
    logic [GHIST_BITS-1:0]   old_history;
    logic                    current_saw_branch_not_taken;
    logic                    new_saw_branch_not_taken;
    logic                    new_saw_branch_taken;
    logic [RAS_IDX_BITS-1:0] ras_idx;
  } ghist_t;
endpackage

// File: rtl/fetch_packet_splitter_slot_select.sv
// Lowest / highest set bit finder over the remaining-slot mask.
module fetch_packet_splitter_slot_select #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  rem_i,
  output logic [SW-1:0] lo_o,
  output logic [SW-1:0] hi_o,
  output logic          any_o
);
  always_comb begin
    lo_o = '0;
    hi_o = '0;
    for (int i = N - 1; i >= 0; i--) if (rem_i[i]) lo_o = SW'(i);
    for (int i = 0; i < N; i++) if (rem_i[i]) hi_o = SW'(i);
    any_o = |rem_i;
  end
endmodule

// File: rtl/fetch_packet_splitter.sv
// Splits a fetch packet into one instruction per cycle; exception packets
// yield a single poisoned output carrying the original pc.
module fetch_packet_splitter
  import fetch_packet_splitter_pkg::*;
#(
  parameter int VADDR_BITS = VADDR_BITS_DEF,
  parameter int NUM_WORDS  = NUM_WORDS_DEF
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          io_flush,
  input  logic                          io_enq_valid,
  output logic                          io_enq_ready,
  input  logic [VADDR_BITS-1:0]         io_enq_bits_pc,
  input  logic [INST_BITS*NUM_WORDS-1:0] io_enq_bits_data,
  input  logic [2*NUM_WORDS-1:0]        io_enq_bits_mask,
  input  logic                          io_enq_bits_xcpt_pf_inst,
  input  logic                          io_enq_bits_xcpt_ae_inst,
  input  logic [GHIST_BITS-1:0]         io_enq_bits_ghist_old_history,
  input  logic                          io_enq_bits_ghist_current_saw_branch_not_taken,
  input  logic                          io_enq_bits_ghist_new_saw_branch_not_taken,
  input  logic                          io_enq_bits_ghist_new_saw_branch_taken,
  input  logic [RAS_IDX_BITS-1:0]       io_enq_bits_ghist_ras_idx,
  output logic                          io_deq_valid,
  input  logic                          io_deq_ready,
  output logic [VADDR_BITS-1:0]         io_deq_bits_pc,
  output logic [INST_BITS-1:0]          io_deq_bits_inst,
  output logic [$clog2(NUM_WORDS)-1:0]  io_deq_bits_slot,
  output logic                          io_deq_bits_last,
  output logic                          io_deq_bits_xcpt_pf_inst,
  output logic                          io_deq_bits_xcpt_ae_inst,
  output logic [GHIST_BITS-1:0]         io_deq_bits_ghist_old_history,
  output logic                          io_deq_bits_ghist_current_saw_branch_not_taken,
  output logic                          io_deq_bits_ghist_new_saw_branch_not_taken,
  output logic                          io_deq_bits_ghist_new_saw_branch_taken,
  output logic [RAS_IDX_BITS-1:0]       io_deq_bits_ghist_ras_idx
);
  localparam int SW    = $clog2(NUM_WORDS);
  localparam int ALIGN = $clog2(4 * NUM_WORDS);

  state_e                        state_q, state_d;
  logic [NUM_WORDS-1:0]          rem_q, rem_d, work;
  logic [VADDR_BITS-1:0]         pc_q;
  logic [INST_BITS*NUM_WORDS-1:0] data_q;
  logic                          pf_q, ae_q, xcpt_q;
  ghist_t                        ghist_q;
  logic [SW-1:0]                 lo, hi;
  logic                          any, last, deq_fire, enq_fire, enq_xcpt;
  logic [VADDR_BITS-1:0]         base_pc;

  fetch_packet_splitter_slot_select #(.N(NUM_WORDS), .SW(SW)) slot_select (
    .rem_i (rem_q),
    .lo_o  (lo),
    .hi_o  (hi),
    .any_o (any)
  );

  assign enq_xcpt = io_enq_bits_xcpt_pf_inst | io_enq_bits_xcpt_ae_inst;

  // A faulting packet is reduced to a single slot-0 output whatever its mask.
  always_comb begin
    work = '0;
    for (int i = 0; i < NUM_WORDS; i++)
      work[i] = io_enq_bits_mask[2*i] & io_enq_bits_mask[2*i+1];
    if (enq_xcpt) work = NUM_WORDS'(1);
  end

  assign last         = (lo == hi);
  assign io_deq_valid = (state_q == S_SPLIT) & any;
  assign deq_fire     = io_deq_valid & io_deq_ready;
  assign io_enq_ready = ~io_flush & ((state_q == S_IDLE) | (deq_fire & last));
  assign enq_fire     = io_enq_valid & io_enq_ready;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (io_flush) begin
      state_d = S_IDLE;
      rem_d   = '0;
    end else begin
      if (deq_fire) begin
        rem_d[lo] = 1'b0;
        if (last) state_d = S_IDLE;
      end
      if (enq_fire) begin
        rem_d   = work;
        state_d = (|work) ? S_SPLIT : S_IDLE;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  always_ff @(posedge clock) begin
    if (enq_fire) begin
      pc_q                 <= io_enq_bits_pc;
      data_q               <= io_enq_bits_data;
      pf_q                 <= io_enq_bits_xcpt_pf_inst;
      ae_q                 <= io_enq_bits_xcpt_ae_inst;
      xcpt_q               <= enq_xcpt;
      ghist_q.old_history  <= io_enq_bits_ghist_old_history;
      ghist_q.current_saw_branch_not_taken <= io_enq_bits_ghist_current_saw_branch_not_taken;
      ghist_q.new_saw_branch_not_taken     <= io_enq_bits_ghist_new_saw_branch_not_taken;
      ghist_q.new_saw_branch_taken         <= io_enq_bits_ghist_new_saw_branch_taken;
      ghist_q.ras_idx      <= io_enq_bits_ghist_ras_idx;
    end
  end

  assign base_pc = {pc_q[VADDR_BITS-1:ALIGN], {ALIGN{1'b0}}};

  assign io_deq_bits_pc   = xcpt_q ? pc_q : base_pc + VADDR_BITS'({lo, 2'b00});
  assign io_deq_bits_inst = xcpt_q ? '0 : data_q[INST_BITS*lo +: INST_BITS];
  assign io_deq_bits_slot = lo;
  assign io_deq_bits_last = last;
  assign io_deq_bits_xcpt_pf_inst = pf_q;
  assign io_deq_bits_xcpt_ae_inst = ae_q;
  assign io_deq_bits_ghist_old_history = ghist_q.old_history;
  assign io_deq_bits_ghist_current_saw_branch_not_taken = ghist_q.current_saw_branch_not_taken;
  assign io_deq_bits_ghist_new_saw_branch_not_taken     = ghist_q.new_saw_branch_not_taken;
  assign io_deq_bits_ghist_new_saw_branch_taken         = ghist_q.new_saw_branch_taken;
  assign io_deq_bits_ghist_ras_idx = ghist_q.ras_idx;
endmodule

// File: tb/tb_fetch_packet_splitter.sv
// Directed + random bench against a queue-of-expected-instructions model.
module tb_fetch_packet_splitter;
  logic         clock = 1'b0;
  logic         reset;
  logic         io_flush, io_enq_valid, io_enq_ready;
  logic [39:0]  io_enq_bits_pc;
  logic [127:0] io_enq_bits_data;
  logic [7:0]   io_enq_bits_mask;
  logic         io_enq_bits_xcpt_pf_inst, io_enq_bits_xcpt_ae_inst;
  logic [63:0]  io_enq_bits_ghist_old_history;
  logic         io_enq_bits_ghist_current_saw_branch_not_taken;
  logic         io_enq_bits_ghist_new_saw_branch_not_taken;
  logic         io_enq_bits_ghist_new_saw_branch_taken;
  logic [4:0]   io_enq_bits_ghist_ras_idx;
  logic         io_deq_valid, io_deq_ready;
  logic [39:0]  io_deq_bits_pc;
  logic [31:0]  io_deq_bits_inst;
  logic [1:0]   io_deq_bits_slot;
  logic         io_deq_bits_last, io_deq_bits_xcpt_pf_inst, io_deq_bits_xcpt_ae_inst;
  logic [63:0]  io_deq_bits_ghist_old_history;
  logic         io_deq_bits_ghist_current_saw_branch_not_taken;
  logic         io_deq_bits_ghist_new_saw_branch_not_taken;
  logic         io_deq_bits_ghist_new_saw_branch_taken;
  logic [4:0]   io_deq_bits_ghist_ras_idx;

  fetch_packet_splitter dut (
    .clock(clock), .reset(reset), .io_flush(io_flush),
    .io_enq_valid(io_enq_valid), .io_enq_ready(io_enq_ready),
    .io_enq_bits_pc(io_enq_bits_pc), .io_enq_bits_data(io_enq_bits_data),
    .io_enq_bits_mask(io_enq_bits_mask),
    .io_enq_bits_xcpt_pf_inst(io_enq_bits_xcpt_pf_inst),
    .io_enq_bits_xcpt_ae_inst(io_enq_bits_xcpt_ae_inst),
    .io_enq_bits_ghist_old_history(io_enq_bits_ghist_old_history),
    .io_enq_bits_ghist_current_saw_branch_not_taken(io_enq_bits_ghist_current_saw_branch_not_taken),
    .io_enq_bits_ghist_new_saw_branch_not_taken(io_enq_bits_ghist_new_saw_branch_not_taken),
    .io_enq_bits_ghist_new_saw_branch_taken(io_enq_bits_ghist_new_saw_branch_taken),
    .io_enq_bits_ghist_ras_idx(io_enq_bits_ghist_ras_idx),
    .io_deq_valid(io_deq_valid), .io_deq_ready(io_deq_ready),
    .io_deq_bits_pc(io_deq_bits_pc), .io_deq_bits_inst(io_deq_bits_inst),
    .io_deq_bits_slot(io_deq_bits_slot), .io_deq_bits_last(io_deq_bits_last),
    .io_deq_bits_xcpt_pf_inst(io_deq_bits_xcpt_pf_inst),
    .io_deq_bits_xcpt_ae_inst(io_deq_bits_xcpt_ae_inst),
    .io_deq_bits_ghist_old_history(io_deq_bits_ghist_old_history),
    .io_deq_bits_ghist_current_saw_branch_not_taken(io_deq_bits_ghist_current_saw_branch_not_taken),
    .io_deq_bits_ghist_new_saw_branch_not_taken(io_deq_bits_ghist_new_saw_branch_not_taken),
    .io_deq_bits_ghist_new_saw_branch_taken(io_deq_bits_ghist_new_saw_branch_taken),
    .io_deq_bits_ghist_ras_idx(io_deq_bits_ghist_ras_idx)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [39:0] pc;
    logic [31:0] inst;
    logic [1:0]  slot;
    logic        last;
  } out_t;

  out_t        q[$];
  logic        m_pf, m_ae, m_cur, m_nnt, m_nt;
  logic [63:0] m_old;
  logic [4:0]  m_ras;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One cycle: drive, check outputs against the model, then advance the model.
  task automatic step(input logic ev, input logic [39:0] pc, input logic [127:0] data,
                      input logic [7:0] mask, input logic pf, input logic ae,
                      input logic dr, input logic fl);
    logic exp_er;
    out_t h, t;
    @(negedge clock);
    io_enq_valid = ev; io_enq_bits_pc = pc; io_enq_bits_data = data;
    io_enq_bits_mask = mask; io_enq_bits_xcpt_pf_inst = pf; io_enq_bits_xcpt_ae_inst = ae;
    io_deq_ready = dr; io_flush = fl;
    io_enq_bits_ghist_old_history = {$urandom, $urandom};
    io_enq_bits_ghist_ras_idx = 5'($urandom);
    {io_enq_bits_ghist_current_saw_branch_not_taken, io_enq_bits_ghist_new_saw_branch_not_taken,
     io_enq_bits_ghist_new_saw_branch_taken} = 3'($urandom);
    #1;
    exp_er = !fl && (q.size() == 0 || (q.size() == 1 && dr));
    chk("deq_valid", 64'(io_deq_valid), 64'(q.size() > 0));
    chk("enq_ready", 64'(io_enq_ready), 64'(exp_er));
    if (q.size() > 0) begin
      h = q[0];
      chk("pc",   64'(io_deq_bits_pc),   64'(h.pc));
      chk("inst", 64'(io_deq_bits_inst), 64'(h.inst));
      chk("slot", 64'(io_deq_bits_slot), 64'(h.slot));
      chk("last", 64'(io_deq_bits_last), 64'(h.last));
      chk("pf",   64'(io_deq_bits_xcpt_pf_inst), 64'(m_pf));
      chk("ae",   64'(io_deq_bits_xcpt_ae_inst), 64'(m_ae));
      chk("ghist_old", io_deq_bits_ghist_old_history, m_old);
      chk("ghist_ras", 64'(io_deq_bits_ghist_ras_idx), 64'(m_ras));
      chk("ghist_bits", 64'({io_deq_bits_ghist_current_saw_branch_not_taken,
          io_deq_bits_ghist_new_saw_branch_not_taken, io_deq_bits_ghist_new_saw_branch_taken}),
          64'({m_cur, m_nnt, m_nt}));
    end
    if (fl) q.delete();
    else begin
      if (q.size() > 0 && dr) void'(q.pop_front());
      if (ev && exp_er) begin
        m_pf = pf; m_ae = ae; m_old = io_enq_bits_ghist_old_history;
        m_ras = io_enq_bits_ghist_ras_idx;
        m_cur = io_enq_bits_ghist_current_saw_branch_not_taken;
        m_nnt = io_enq_bits_ghist_new_saw_branch_not_taken;
        m_nt  = io_enq_bits_ghist_new_saw_branch_taken;
        if (pf || ae) q.push_back('{pc, 32'h0, 2'd0, 1'b1});
        else begin
          for (int i = 0; i < 4; i++)
            if (mask[2*i] && mask[2*i+1])
              q.push_back('{{pc[39:4], 4'h0} + 40'(4 * i), data[32*i +: 32], 2'(i), 1'b0});
          if (q.size() > 0) begin
            t = q.pop_back(); t.last = 1'b1; q.push_back(t);
          end
        end
      end
    end
  endtask

  task automatic idle(input logic dr);
    step(1'b0, 40'h0, 128'h0, 8'h0, 1'b0, 1'b0, dr, 1'b0);
  endtask

  initial begin
    reset = 1'b1; io_flush = 1'b0; io_enq_valid = 1'b0; io_deq_ready = 1'b0;
    io_enq_bits_pc = '0; io_enq_bits_data = '0; io_enq_bits_mask = '0;
    io_enq_bits_xcpt_pf_inst = 1'b0; io_enq_bits_xcpt_ae_inst = 1'b0;
    io_enq_bits_ghist_old_history = '0; io_enq_bits_ghist_ras_idx = '0;
    io_enq_bits_ghist_current_saw_branch_not_taken = 1'b0;
    io_enq_bits_ghist_new_saw_branch_not_taken = 1'b0;
    io_enq_bits_ghist_new_saw_branch_taken = 1'b0;
    #1 chk("rst_deq_valid", 64'(io_deq_valid), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1 chk("rst_enq_ready", 64'(io_enq_ready), 64'd1);

    // full packet, four consecutive outputs
    step(1'b1, 40'h1000, rnd128(), 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) idle(1'b1);
    // slots 0 and 2, next packet accepted alongside the last output
    step(1'b1, 40'h2008, rnd128(), 8'h33, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    step(1'b1, 40'h2010, rnd128(), 8'h0F, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) idle(1'b1);
    // exception packet
    step(1'b1, 40'h3006, rnd128(), 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    step(1'b1, 40'h3106, rnd128(), 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    // empty packet dropped, next accepted the following cycle
    step(1'b1, 40'h4000, rnd128(), 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 40'h4010, rnd128(), 8'h0C, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    // stall then flush
    step(1'b1, 40'h5000, rnd128(), 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    repeat (3) idle(1'b0);
    step(1'b1, 40'h5100, rnd128(), 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    // pc wrap at top of the address space
    step(1'b1, 40'hFF_FFFF_FFF0, rnd128(), 8'hC0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    step(1'b1, 40'hFF_FFFF_FFF4, rnd128(), 8'hF3, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) idle(1'b1);
    // async reset mid-packet
    step(1'b1, 40'h6000, rnd128(), 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    @(negedge clock);
    io_enq_valid = 1'b0;
    #2 reset = 1'b1;
    #1 chk("rst_mid_deq_valid", 64'(io_deq_valid), 64'd0);
    q.delete();
    @(negedge clock);
    reset = 1'b0;
    idle(1'b1);

    // random run
    for (int c = 0; c < 1500; c++) begin
      logic [7:0] m;
      m = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 3) == 0) m = 8'hFF;
      step($urandom_range(0, 2) != 0, {$urandom, $urandom}, rnd128(), m,
           $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end
    repeat (6) idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
